// File: rtl/sysid_regbank_if.sv
// Avalon-MM slave bus for the system-ID register bank.
// There is no waitrequest, so read or write is accepted on every cycle its strobe is high.
// readdatavalid pulses once per accepted read, and readdata is qualified by it.
interface sysid_regbank_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regbank.sv
// System-ID register bank: fixed ID/timestamp, scratch, 64-bit uptime counter with
// high-word snapshot, control register and user build words behind a pipelined read path.
module sysid_regbank #(
  parameter logic [31:0]            ID_VALUE      = 32'h0000_0000,
  parameter logic [31:0]            TIMESTAMP     = 32'd1476934705,
  parameter logic [31:0]            SCRATCH_RESET = 32'h0000_0000,
  parameter int                     NUM_USER      = 2,
  parameter logic [32*NUM_USER-1:0] USER_WORDS    = '0,
  parameter int                     ADDR_W        = 4,
  parameter int                     READ_LATENCY  = 1
) (
  input  logic            clock,
  input  logic            reset,
  sysid_regbank_if.slave  bus
);

  localparam int A_SYSID   = 0;
  localparam int A_TSTAMP  = 1;
  localparam int A_SCRATCH = 2;
  localparam int A_UP_LO   = 3;
  localparam int A_UP_HI   = 4;
  localparam int A_CONTROL = 5;
  localparam int A_USER0   = 6;

  logic [31:0] scratch_q, scratch_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic        en_q, en_d;
  logic [READ_LATENCY-1:0]       vld_q, vld_d;
  logic [READ_LATENCY-1:0][31:0] dat_q, dat_d;

  logic        rd_acc;
  logic        wr_acc;
  logic        clr;
  int          addr;
  logic [31:0] rd_mux;

  always_comb begin
    // A simultaneous read and write performs only the write.
    rd_acc   = bus.read && !bus.write;
    wr_acc   = bus.write;
    addr     = int'(bus.address);
    rd_mux   = '0;
    case (addr)
      A_SYSID:   rd_mux = ID_VALUE;
      A_TSTAMP:  rd_mux = TIMESTAMP;
      A_SCRATCH: rd_mux = scratch_q;
      A_UP_LO:   rd_mux = cnt_q[31:0];
      A_UP_HI:   rd_mux = shadow_q;
      A_CONTROL: rd_mux = {31'b0, en_q};
      default:   rd_mux = '0;
    endcase
    for (int k = 0; k < NUM_USER; k++) begin
      if (addr == A_USER0 + k) rd_mux = USER_WORDS[32*k +: 32];
    end

    scratch_d = scratch_q;
    if (wr_acc && addr == A_SCRATCH) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteenable[b]) scratch_d[8*b +: 8] = bus.writedata[8*b +: 8];
      end
    end

    en_d = en_q;
    clr  = 1'b0;
    if (wr_acc && addr == A_CONTROL && bus.byteenable[0]) begin
      en_d = bus.writedata[0];
      clr  = bus.writedata[1];
    end

    // Clear wins over increment; the new EN takes effect from the following edge.
    if (clr)       cnt_d = '0;
    else if (en_q) cnt_d = cnt_q + 64'd1;
    else           cnt_d = cnt_q;

    shadow_d = shadow_q;
    if (rd_acc && addr == A_UP_LO) shadow_d = cnt_q[63:32];

    // Data stages only move with a valid token so readdata holds between pulses.
    vld_d[0] = rd_acc;
    dat_d[0] = rd_acc ? rd_mux : dat_q[0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch_q <= SCRATCH_RESET;
      cnt_q     <= '0;
      shadow_q  <= '0;
      en_q      <= 1'b1;
      vld_q     <= '0;
      dat_q     <= '0;
    end else begin
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      en_q      <= en_d;
      vld_q     <= vld_d;
      dat_q     <= dat_d;
    end
  end

  assign bus.readdata      = dat_q[READ_LATENCY-1];
  assign bus.readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_regbank.sv
// Directed bench for sysid_regbank: a READ_LATENCY=2 instance for the register map
// and a READ_LATENCY=3 instance for reset with a read in flight.
module tb_sysid_regbank;

  logic clk;
  logic rst;
  logic rst3;
  int   n_checks;
  int   n_fail;

  sysid_regbank_if #(.ADDR_W(4)) bus ();
  sysid_regbank_if #(.ADDR_W(4)) bus3 ();

  sysid_regbank #(
    .ID_VALUE     (32'hCAFE_0001),
    .TIMESTAMP    (32'd1476934705),
    .SCRATCH_RESET(32'h0000_0000),
    .NUM_USER     (2),
    .USER_WORDS   ({32'h2, 32'h1}),
    .ADDR_W       (4),
    .READ_LATENCY (2)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  sysid_regbank #(
    .ID_VALUE     (32'h0000_1234),
    .NUM_USER     (2),
    .USER_WORDS   ({32'h2, 32'h1}),
    .ADDR_W       (4),
    .READ_LATENCY (3)
  ) dut3 (
    .clock(clk),
    .reset(rst3),
    .bus  (bus3.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic bus_idle();
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.byteenable = '0; bus.writedata = '0;
    bus3.address = '0; bus3.read = 1'b0; bus3.write = 1'b0;
    bus3.byteenable = '0; bus3.writedata = '0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address = a; bus.write = 1'b1; bus.writedata = d; bus.byteenable = be;
    @(negedge clk);
    bus.write = 1'b0; bus.byteenable = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic ok);
    ok = 1'b0;
    d  = '0;
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.readdatavalid) begin
        ok = 1'b1;
        d  = bus.readdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic        ok;
    n_checks++;
    if (bus.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdv: got %b expected 0", bus.readdatavalid);
    end
    n_checks++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", bus.readdata);
    end
    @(negedge clk); rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    bus_read(4'd5, d, ok);
    n_checks++;
    if (!ok || d !== 32'h1) begin
      n_fail++; $display("FAIL reset_control: ok=%b got %h expected 00000001", ok, d);
    end
    bus_read(4'd2, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0) begin
      n_fail++; $display("FAIL reset_scratch: ok=%b got %h expected 00000000", ok, d);
    end
    bus_read(4'd4, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0) begin
      n_fail++; $display("FAIL reset_shadow: ok=%b got %h expected 00000000", ok, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  addrs [4];
    logic        got_v [7];
    logic [31:0] got_d [7];
    logic        exp_v [7];
    logic [31:0] exp_d [7];
    addrs = '{4'd0, 4'd1, 4'd6, 4'd7};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_d = '{32'h0, 32'hCAFE_0001, 32'd1476934705, 32'h1, 32'h2, 32'h0, 32'h0};
    bus.address = addrs[0]; bus.read = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      got_v[i] = bus.readdatavalid;
      got_d[i] = bus.readdata;
      if (i < 3) bus.address = addrs[i+1];
      else       bus.read = 1'b0;
    end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (got_v[i] !== exp_v[i]) begin
        n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, got_v[i], exp_v[i]);
      end
      if (exp_v[i]) begin
        n_checks++;
        if (got_d[i] !== exp_d[i]) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_d[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    logic        ok;
    bus_write(4'd2, 32'hFFFF_FFFF, 4'b1111);
    bus_write(4'd2, 32'h1234_5678, 4'b0101);
    bus_read(4'd2, d, ok);
    n_checks++;
    if (!ok || d !== 32'hFF34_FF78) begin
      n_fail++; $display("FAIL scratch_byteen: ok=%b got %h expected ff34ff78", ok, d);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic        ok;
    bus_write(4'd0, 32'hDEAD_BEEF, 4'b1111);
    bus_read(4'd0, d, ok);
    n_checks++;
    if (!ok || d !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL ro_write_ignored: ok=%b got %h expected cafe0001", ok, d);
    end
    bus_read(4'd8, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_8: ok=%b got %h expected 00000000", ok, d);
    end
    bus_read(4'd15, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_15: ok=%b got %h expected 00000000", ok, d);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic        ok;
    bus_write(4'd5, 32'h0, 4'b0001);
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
    idle_cycles(2);
    release dut.cnt_q;
    // Enabled at the next edge; two further edges take FFFF_FFFE to 1_0000_0000.
    bus_write(4'd5, 32'h1, 4'b0001);
    idle_cycles(2);
    bus_read(4'd3, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_lo: ok=%b got %h expected 00000000", ok, d);
    end
    idle_cycles(6);
    bus_read(4'd4, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0001) begin
      n_fail++; $display("FAIL wrap_hi_shadow: ok=%b got %h expected 00000001", ok, d);
    end
  endtask

  task automatic test_enable_clear();
    logic [31:0] d1, d2;
    logic        ok1, ok2;
    bus_write(4'd5, 32'h0, 4'b0001);
    idle_cycles(10);
    bus_read(4'd3, d1, ok1);
    bus_read(4'd3, d2, ok2);
    n_checks++;
    if (!ok1 || !ok2 || d1 !== d2) begin
      n_fail++; $display("FAIL en_stopped: got %h then %h expected equal", d1, d2);
    end
    bus_write(4'd5, 32'h3, 4'b0001);
    bus_read(4'd3, d1, ok1);
    n_checks++;
    if (!ok1 || d1 > 32'd2) begin
      n_fail++; $display("FAIL clr_restart: ok=%b got %h expected <= 2", ok1, d1);
    end
    bus_read(4'd5, d1, ok1);
    n_checks++;
    if (!ok1 || d1 !== 32'h1) begin
      n_fail++; $display("FAIL control_readback: ok=%b got %h expected 00000001", ok1, d1);
    end
    bus_write(4'd5, 32'h2, 4'b0001);
    idle_cycles(4);
    bus_read(4'd3, d1, ok1);
    n_checks++;
    if (!ok1 || d1 !== 32'h0) begin
      n_fail++; $display("FAIL clr_stopped: ok=%b got %h expected 00000000", ok1, d1);
    end
    // CONTROL ignores a write without byteenable[0].
    bus_write(4'd5, 32'h1, 4'b1110);
    idle_cycles(3);
    bus_read(4'd3, d1, ok1);
    n_checks++;
    if (!ok1 || d1 !== 32'h0) begin
      n_fail++; $display("FAIL control_be0: ok=%b got %h expected 00000000", ok1, d1);
    end
    bus_write(4'd5, 32'h1, 4'b0001);
  endtask

  task automatic test_rw_collision();
    logic [31:0] d;
    logic        ok;
    logic        seen;
    seen = 1'b0;
    bus.address = 4'd2; bus.read = 1'b1; bus.write = 1'b1;
    bus.writedata = 32'hA5A5_A5A5; bus.byteenable = 4'hF;
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0; bus.byteenable = '0;
    for (int i = 0; i < 5; i++) begin
      if (bus.readdatavalid) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL collision_no_rdv: got %b expected 0", seen);
    end
    bus_read(4'd2, d, ok);
    n_checks++;
    if (!ok || d !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL collision_write: ok=%b got %h expected a5a5a5a5", ok, d);
    end
  endtask

  task automatic test_reset_in_flight();
    logic seen_v;
    logic bad_d;
    seen_v = 1'b0;
    bad_d  = 1'b0;
    bus3.address = 4'd0; bus3.read = 1'b1;
    @(negedge clk);
    bus3.read = 1'b0;
    if (bus3.readdatavalid) seen_v = 1'b1;
    @(posedge clk);
    #1 rst3 = 1'b1;
    #1;
    if (bus3.readdatavalid) seen_v = 1'b1;
    if (bus3.readdata !== 32'h0) bad_d = 1'b1;
    idle_cycles(2);
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus3.readdatavalid) seen_v = 1'b1;
      if (bus3.readdata !== 32'h0) bad_d = 1'b1;
    end
    n_checks++;
    if (seen_v !== 1'b0) begin
      n_fail++; $display("FAIL inflight_rdv: got %b expected 0", seen_v);
    end
    n_checks++;
    if (bad_d !== 1'b0) begin
      n_fail++; $display("FAIL inflight_rdata: got %h expected 00000000", bus3.readdata);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    rst3 = 1'b1;
    bus_idle();
    idle_cycles(2);
    test_reset();
    test_back_to_back();
    test_scratch();
    test_unmapped();
    test_wrap();
    test_enable_clear();
    test_rw_collision();
    test_reset_in_flight();
    idle_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sysid_regbank.md
# sysid_regbank

Parametrised successor to the Qsys system-ID slave. It is an Avalon-MM register bank that returns a fixed system ID and build timestamp, plus:
- a byte-writable scratch register,
- a 64-bit free-running uptime counter with atomic high-word snapshot,
- a control register,
- a parameterised list of user build words.

It sits on the HPS/Nios lightweight bus next to the other Qsys peripherals. Software uses it to identify the bitstream and to timestamp events.

## Interface
- ID_VALUE, 32'h0000_0000: value returned at word 0.
- TIMESTAMP, 1476934705: value returned at word 1.
- SCRATCH_RESET, 32'h0000_0000: reset value of the scratch register.
- NUM_USER, 2: number of user words, 0..8.
- USER_WORDS, {NUM_USER{32'h0}}: flattened user words; word k is bits [32k+31:32k].
- ADDR_W, 4: word-address width. Must satisfy 6+NUM_USER <= 2^ADDR_W.
- READ_LATENCY, 1: read latency in cycles, 1..3.

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe.
- write  in  1  write strobe.
- byteenable  in  4  byte lanes for writes.
- writedata  in  32  write data.
- readdata  out  32  read data, qualified by readdatavalid.
- readdatavalid  out  1  one-cycle pulse per accepted read.

## Operation
Register map (word address):
- 0 SYSID: RO, returns ID_VALUE.
- 1 TIMESTAMP: RO, returns TIMESTAMP.
- 2 SCRATCH: RW. Each written byte is gated by its byteenable bit.
- 3 UPTIME_LO: RO, returns counter[31:0]. The same read copies counter[63:32] into the shadow register.
- 4 UPTIME_HI: RO, returns the shadow register, never the live high word.
- 5 CONTROL:
  - bit0 EN: RW, reset 1. Counter increments only while EN=1.
  - bit1 CLR: write-1 clears the counter. Self-clearing; reads as 0.
  - bits 31:2 read 0.
  - Writes to CONTROL use byteenable[0] only.
- 6..5+NUM_USER USER[k]: RO, returns USER_WORDS word k.
- All other addresses read 0. Writes to RO or unmapped addresses are ignored.

Behaviour:
- No waitrequest. A read or write is accepted on every cycle its strobe is high, so back-to-back pipelined reads run at one per cycle.
- Read data is sampled at the acceptance edge, then delayed through a READ_LATENCY-stage pipeline.
- read and write high together is illegal. The block performs the write and drops the read: no readdatavalid for it.
- Uptime counter is 64-bit and increments by 1 per clock when EN=1. It wraps from 2^64-1 to 0 with no flag.
- CLR has priority over increment: on the edge of the CLR write, the counter becomes 0. If EN=1, it increments from 0 starting the following edge.
- A write that sets EN=0 together with CLR=1 leaves the counter at 0 and stopped.

## Timing
- Reset (asynchronous, effective immediately) sets:
  - readdata 0, readdatavalid 0, all pipeline stages invalid;
  - counter 0, shadow 0, EN 1, scratch SCRATCH_RESET.
- Read accepted at edge T:
  - readdatavalid is high for exactly the cycle after edge T+READ_LATENCY-1. With READ_LATENCY=1, it is valid in the cycle following acceptance.
  - readdata holds the returned value in that same cycle and holds its last value otherwise.
- UPTIME_LO read accepted at edge T: it returns the counter value present before edge T, i.e. the value seen in the request cycle. The shadow captures the high word of that same value at edge T.
- A write at edge T is visible to a read accepted at edge T+1.
- Reset asserted with reads in flight: the pending readdatavalid pulses are discarded and never emitted after reset release.
- Counter wrap: 32'hFFFF_FFFF to 0 in the low word carries into the high word on the same edge.

## Test plan
- Reset, then read words 0, 1, 6 and 7 back-to-back with ID_VALUE=32'hCAFE_0001, NUM_USER=2, USER_WORDS={32'h2,32'h1}, READ_LATENCY=2:
  - readdatavalid on 4 consecutive cycles, starting 2 cycles after the first request;
  - data 32'hCAFE_0001, 1476934705, 32'h1, 32'h2.
- Write SCRATCH 32'hFFFF_FFFF with byteenable 4'b1111, then 32'h1234_5678 with byteenable 4'b0101, then read word 2 -> 32'hFF34_FF78.
- Force counter to 64'h0000_0000_FFFF_FFFE, wait 2 cycles, read words 3 then 4 -> 32'h0000_0000 then 32'h0000_0001. The shadow must hold while further cycles elapse before the HI read.
- Write CONTROL 32'h0 (EN=0), wait 10 cycles, read UPTIME_LO twice -> identical values. Then write CONTROL 32'h3 -> the next UPTIME_LO read returns a value ≤ 2.
- Issue a read with READ_LATENCY=3 and assert reset 1 cycle after acceptance -> no readdatavalid before or after reset release; readdata is 0.
- Assert read and write to SCRATCH together with writedata 32'hA5A5_A5A5 -> no readdatavalid; a subsequent read of word 2 returns 32'hA5A5_A5A5.
